// File: rtl/dcache_warmup_pkg.sv
// Shared geometry, record/state types and lane helpers for the DCache warmup loader.
// Geometry: 64 sets x 4 ways, 8 rows of 8 bytes per line, 22-bit tag entries.
package dcache_warmup_pkg;

  localparam int unsigned SETS      = 64;
  localparam int unsigned WAYS      = 4;
  localparam int unsigned ROWS      = 8;
  localparam int unsigned ROW_BYTES = 8;
  localparam int unsigned TAG_BITS  = 22;

  localparam int unsigned SB      = $clog2(SETS);
  localparam int unsigned WB      = $clog2(WAYS);
  localparam int unsigned RB      = $clog2(ROWS);
  localparam int unsigned AB      = SB + RB;
  localparam int unsigned PAY_W   = 64;
  localparam int unsigned ROW_W   = ROW_BYTES * 8;
  localparam int unsigned TAG_W   = WAYS * TAG_BITS;
  localparam int unsigned DATA_W  = WAYS * ROW_W;
  localparam int unsigned DMASK_W = WAYS * ROW_BYTES;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic {
    KIND_TAG  = 1'b0,
    KIND_DATA = 1'b1
  } kind_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // One captured checkpoint record
  typedef struct packed {
    kind_e            kind;
    logic [WB-1:0]    way;
    logic [SB-1:0]    set_idx;
    logic [RB-1:0]    row_idx;
    logic [PAY_W-1:0] data;
    logic             last;
  } rec_t;

  // Copy one tag entry into every way lane; the mask picks the real target
  function automatic logic [TAG_W-1:0] tag_replicate(input logic [TAG_BITS-1:0] tag);
    logic [TAG_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WAYS; i++) r[i*TAG_BITS +: TAG_BITS] = tag;
    return r;
  endfunction

  // Copy one data row into every way lane
  function automatic logic [DATA_W-1:0] row_replicate(input logic [ROW_W-1:0] row);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WAYS; i++) r[i*ROW_W +: ROW_W] = row;
    return r;
  endfunction

  function automatic logic [TAG_BITS-1:0] tag_select(input logic [TAG_W-1:0] rdata,
                                                     input logic [WB-1:0]    way);
    return rdata[way*TAG_BITS +: TAG_BITS];
  endfunction

  function automatic logic [ROW_W-1:0] row_select(input logic [DATA_W-1:0] rdata,
                                                  input logic [WB-1:0]     way);
    return rdata[way*ROW_W +: ROW_W];
  endfunction

  // One-hot way mask for the tag array
  function automatic logic [WAYS-1:0] tag_mask(input logic [WB-1:0] way);
    logic [WAYS-1:0] r;
    r      = '0;
    r[way] = 1'b1;
    return r;
  endfunction

  // Byte mask covering the whole row of one way
  function automatic logic [DMASK_W-1:0] data_mask(input logic [WB-1:0] way);
    logic [DMASK_W-1:0] r;
    r = '0;
    r[way*ROW_BYTES +: ROW_BYTES] = '1;
    return r;
  endfunction

endpackage

// File: rtl/dcache_warmup_loader.sv
// DCache warmup loader: takes checkpoint records (tag entries / data rows) and writes
// them through the tag and data array RW0 ports, optionally reading each one back.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   start, verify_en                 session start pulse, read-back enable (sampled at start)
//   in_valid/in_ready, in_kind,      record handshake and fields
//   in_way, in_set, in_row,
//   in_data, in_last
//   tag_*                            tag array RW0 controls / data
//   data_*                           data array RW0 controls / data
//   busy, done                       session status
//   rec_count, err_count             accepted records, saturating mismatch count
//   err_valid/kind/way/addr          first mismatch capture
module dcache_warmup_loader
  import dcache_warmup_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               verify_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_kind,
  input  logic [WB-1:0]      in_way,
  input  logic [SB-1:0]      in_set,
  input  logic [RB-1:0]      in_row,
  input  logic [PAY_W-1:0]   in_data,
  input  logic               in_last,
  output logic [SB-1:0]      tag_addr,
  output logic               tag_en,
  output logic               tag_wmode,
  output logic [TAG_W-1:0]   tag_wdata,
  output logic [WAYS-1:0]    tag_wmask,
  input  logic [TAG_W-1:0]   tag_rdata,
  output logic [AB-1:0]      data_addr,
  output logic               data_en,
  output logic               data_wmode,
  output logic [DATA_W-1:0]  data_wdata,
  output logic [DMASK_W-1:0] data_wmask,
  input  logic [DATA_W-1:0]  data_rdata,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   rec_count,
  output logic [CNT_W-1:0]   err_count,
  output logic               err_valid,
  output logic               err_kind,
  output logic [WB-1:0]      err_way,
  output logic [AB-1:0]      err_addr
);

  state_e        state, state_n;
  rec_t          cap;
  logic          verify_q;
  logic          start_ok;
  logic          accept;
  logic          check_en;
  logic          mismatch;
  logic [AB-1:0] cap_addr;

  assign cap_addr = {cap.set_idx, cap.row_idx};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_n  = state;
    start_ok = 1'b0;
    accept   = 1'b0;
    check_en = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_ok = 1'b1;
          state_n  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (verify_q)      state_n = S_READ;
        else if (cap.last) state_n = S_DONE;
        else               state_n = S_LOAD;
      end
      S_READ:  state_n = S_CHECK;
      S_CHECK: begin
        check_en = 1'b1;
        state_n  = cap.last ? S_DONE : S_LOAD;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Read-back comparison against the lane of the captured way
  always_comb begin
    mismatch = 1'b0;
    if (cap.kind == KIND_TAG)
      mismatch = (tag_select(tag_rdata, cap.way) != cap.data[TAG_BITS-1:0]);
    else
      mismatch = (row_select(data_rdata, cap.way) != cap.data);
  end

  // Record capture, counters and first-error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap       <= '0;
      verify_q  <= 1'b0;
      rec_count <= '0;
      err_count <= '0;
      err_valid <= 1'b0;
      err_kind  <= 1'b0;
      err_way   <= '0;
      err_addr  <= '0;
    end else begin
      if (start_ok) begin
        verify_q  <= verify_en;
        rec_count <= '0;
        err_count <= '0;
        err_valid <= 1'b0;
        err_kind  <= 1'b0;
        err_way   <= '0;
        err_addr  <= '0;
      end
      if (accept) begin
        cap.kind    <= kind_e'(in_kind);
        cap.way     <= in_way;
        cap.set_idx <= in_set;
        cap.row_idx <= in_row;
        cap.data    <= in_data;
        cap.last    <= in_last;
        rec_count   <= rec_count + CNT_W'(1);
      end
      if (check_en && mismatch) begin
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
        if (!err_valid) begin
          err_valid <= 1'b1;
          err_kind  <= cap.kind;
          err_way   <= cap.way;
          err_addr  <= (cap.kind == KIND_TAG) ? AB'(cap.set_idx) : cap_addr;
        end
      end
    end
  end

  // Status flags registered from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= (state_n == S_LOAD);
      busy     <= (state_n == S_LOAD) || (state_n == S_WRITE) ||
                  (state_n == S_READ) || (state_n == S_CHECK);
      done     <= (state_n == S_DONE);
    end
  end

  // SRAM port drive; strobes only in WRITE/READ, address/data follow the capture registers
  always_comb begin
    tag_en     = 1'b0;
    tag_wmode  = 1'b0;
    tag_wmask  = '0;
    data_en    = 1'b0;
    data_wmode = 1'b0;
    data_wmask = '0;
    tag_addr   = cap.set_idx;
    tag_wdata  = tag_replicate(cap.data[TAG_BITS-1:0]);
    data_addr  = cap_addr;
    data_wdata = row_replicate(cap.data);
    if (cap.kind == KIND_TAG) begin
      if (state == S_WRITE) begin
        tag_en    = 1'b1;
        tag_wmode = 1'b1;
        tag_wmask = tag_mask(cap.way);
      end else if (state == S_READ) begin
        tag_en    = 1'b1;
      end
    end else begin
      if (state == S_WRITE) begin
        data_en    = 1'b1;
        data_wmode = 1'b1;
        data_wmask = data_mask(cap.way);
      end else if (state == S_READ) begin
        data_en    = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_warmup_loader.sv
// Directed bench for dcache_warmup_loader with a behavioural tag/data SRAM model.
module tb_dcache_warmup_loader;
  import dcache_warmup_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               verify_en;
  logic               in_valid;
  logic               in_ready;
  logic               in_kind;
  logic [WB-1:0]      in_way;
  logic [SB-1:0]      in_set;
  logic [RB-1:0]      in_row;
  logic [PAY_W-1:0]   in_data;
  logic               in_last;
  logic [SB-1:0]      tag_addr;
  logic               tag_en;
  logic               tag_wmode;
  logic [TAG_W-1:0]   tag_wdata;
  logic [WAYS-1:0]    tag_wmask;
  logic [TAG_W-1:0]   tag_rdata;
  logic [AB-1:0]      data_addr;
  logic               data_en;
  logic               data_wmode;
  logic [DATA_W-1:0]  data_wdata;
  logic [DMASK_W-1:0] data_wmask;
  logic [DATA_W-1:0]  data_rdata;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   rec_count;
  logic [CNT_W-1:0]   err_count;
  logic               err_valid;
  logic               err_kind;
  logic [WB-1:0]      err_way;
  logic [AB-1:0]      err_addr;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  logic        corrupt = 1'b0;

  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [DATA_W-1:0] data_mem [SETS*ROWS];

  dcache_warmup_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .verify_en  (verify_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_way     (in_way),
    .in_set     (in_set),
    .in_row     (in_row),
    .in_data    (in_data),
    .in_last    (in_last),
    .tag_addr   (tag_addr),
    .tag_en     (tag_en),
    .tag_wmode  (tag_wmode),
    .tag_wdata  (tag_wdata),
    .tag_wmask  (tag_wmask),
    .tag_rdata  (tag_rdata),
    .data_addr  (data_addr),
    .data_en    (data_en),
    .data_wmode (data_wmode),
    .data_wdata (data_wdata),
    .data_wmask (data_wmask),
    .data_rdata (data_rdata),
    .busy       (busy),
    .done       (done),
    .rec_count  (rec_count),
    .err_count  (err_count),
    .err_valid  (err_valid),
    .err_kind   (err_kind),
    .err_way    (err_way),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RW0 SRAM models, one-cycle read latency; corrupt flips bit 0 of every data lane
  always @(posedge clk) begin
    if (tag_en) begin
      if (tag_wmode) begin
        for (int i = 0; i < WAYS; i++)
          if (tag_wmask[i]) tag_mem[tag_addr][i*TAG_BITS +: TAG_BITS] <= tag_wdata[i*TAG_BITS +: TAG_BITS];
      end else begin
        tag_rdata <= tag_mem[tag_addr];
      end
    end
    if (data_en) begin
      if (data_wmode) begin
        for (int b = 0; b < DMASK_W; b++)
          if (data_wmask[b]) data_mem[data_addr][b*8 +: 8] <= data_wdata[b*8 +: 8];
      end else begin
        data_rdata <= data_mem[data_addr] ^ (corrupt ? {WAYS{64'h1}} : '0);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_session(input logic ver);
    verify_en = ver;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Presents one record and returns #1 after the accepting edge (DUT then in WRITE)
  task automatic send_rec(input logic k, input logic [WB-1:0] w, input logic [SB-1:0] s,
                          input logic [RB-1:0] r, input logic [63:0] d, input logic l);
    int unsigned n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_kind  = k;
    in_way   = w;
    in_set   = s;
    in_row   = r;
    in_data  = d;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  initial begin #1_000_000; $display("FAIL watchdog: simulation did not finish"); $fatal; end

  initial begin
    int unsigned first_acc, prev_acc, gap_bad, n;
    logic [63:0] exp_d;
    logic [AB-1:0] a;
    rst_n = 1'b0; start = 1'b0; verify_en = 1'b0; in_valid = 1'b0;
    in_kind = 1'b0; in_way = '0; in_set = '0; in_row = '0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",      64'(busy), 64'd0);
    chk("rst_done",      64'(done), 64'd0);
    chk("rst_in_ready",  64'(in_ready), 64'd0);
    chk("rst_rec_count", 64'(rec_count), 64'd0);
    chk("rst_tag_en",    64'(tag_en), 64'd0);
    chk("rst_data_en",   64'(data_en), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tag record, verify off
    start_session(1'b0);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    send_rec(1'b0, 2'd2, 6'd5, 3'd0, 64'h2ABCDE, 1'b1);
    chk("t1_tag_en",    64'(tag_en), 64'd1);
    chk("t1_tag_wmode", 64'(tag_wmode), 64'd1);
    chk("t1_tag_addr",  64'(tag_addr), 64'd5);
    chk("t1_tag_wmask", 64'(tag_wmask), 64'h4);
    chk("t1_lane2",     64'(tag_wdata[2*TAG_BITS +: TAG_BITS]), 64'h2ABCDE);
    chk("t1_data_en",   64'(data_en), 64'd0);
    @(posedge clk); #1;
    chk("t1_done",      64'(done), 64'd1);
    chk("t1_busy",      64'(busy), 64'd0);
    chk("t1_tag_en_off",64'(tag_en), 64'd0);
    chk("t1_rec_count", 64'(rec_count), 64'd1);
    chk("t1_mem",       64'(tag_mem[5][2*TAG_BITS +: TAG_BITS]), 64'h2ABCDE);

    // Data record, verify on, clean read-back
    start_session(1'b1);
    send_rec(1'b1, 2'd3, 6'd63, 3'd7, 64'h0123456789ABCDEF, 1'b1);
    chk("t2_data_addr",  64'(data_addr), 64'd511);
    chk("t2_data_wmask", 64'(data_wmask), 64'hFF000000);
    chk("t2_data_wmode", 64'(data_wmode), 64'd1);
    chk("t2_lane3",      data_wdata[3*64 +: 64], 64'h0123456789ABCDEF);
    @(posedge clk); #1;
    chk("t2_rd_en",      64'(data_en), 64'd1);
    chk("t2_rd_wmode",   64'(data_wmode), 64'd0);
    chk("t2_rd_wmask",   64'(data_wmask), 64'd0);
    wait_done();
    chk("t2_err_count",  64'(err_count), 64'd0);
    chk("t2_err_valid",  64'(err_valid), 64'd0);

    // Verify on: clean tag record, then corrupted data record
    start_session(1'b1);
    corrupt = 1'b1;
    send_rec(1'b0, 2'd0, 6'd9, 3'd0, 64'h155555, 1'b0);
    send_rec(1'b1, 2'd1, 6'd0, 3'd1, 64'hDEADBEEFCAFEF00D, 1'b1);
    wait_done();
    corrupt = 1'b0;
    chk("t3_err_count", 64'(err_count), 64'd1);
    chk("t3_err_valid", 64'(err_valid), 64'd1);
    chk("t3_err_kind",  64'(err_kind), 64'd1);
    chk("t3_err_way",   64'(err_way), 64'd1);
    chk("t3_err_addr",  64'(err_addr), 64'd1);
    chk("t3_rec_count", 64'(rec_count), 64'd2);

    // Start from DONE clears session state; 256-record back-to-back stream
    start_session(1'b0);
    chk("t4_done_clr",  64'(done), 64'd0);
    chk("t4_err_clr",   64'(err_count), 64'd0);
    chk("t4_errv_clr",  64'(err_valid), 64'd0);
    chk("t4_rec_clr",   64'(rec_count), 64'd0);
    chk("t4_busy",      64'(busy), 64'd1);
    first_acc = 0; prev_acc = 0; gap_bad = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      n = 0;
      while (!in_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (!in_ready) chk("t4_ready_timeout", 64'(in_ready), 64'd1);
      in_kind = 1'b1;
      in_way  = WB'(i % 4);
      in_set  = SB'(i % 64);
      in_row  = RB'(i / 64);
      in_data = {32'hC0DE0000 + 32'(i), 32'(i)};
      in_last = (i == 255);
      @(posedge clk); #1;
      if (i == 0) first_acc = cyc;
      else if (cyc - prev_acc != 2) gap_bad++;
      prev_acc = cyc;
    end
    in_valid = 1'b0;
    wait_done();
    chk("t4_gap",       64'(gap_bad), 64'd0);
    chk("t4_span",      64'(prev_acc - first_acc), 64'd510);
    chk("t4_rec_count", 64'(rec_count), 64'd256);
    a     = {6'd8, 3'd3};
    exp_d = {32'hC0DE00C8, 32'd200};
    chk("t4_mem200",    data_mem[a][0 +: 64], exp_d);

    // Start pulsed in WRITE is ignored
    start_session(1'b0);
    send_rec(1'b0, 2'd1, 6'd3, 3'd0, 64'h3, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_rec_kept",  64'(rec_count), 64'd1);
    chk("t5_in_ready",  64'(in_ready), 64'd1);
    send_rec(1'b0, 2'd2, 6'd4, 3'd0, 64'h4, 1'b1);
    wait_done();
    chk("t5_rec_count", 64'(rec_count), 64'd2);

    // Async reset while in WRITE
    start_session(1'b0);
    send_rec(1'b1, 2'd0, 6'd1, 3'd2, 64'h55AA, 1'b1);
    chk("t6_pre_data_en", 64'(data_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_data_en",   64'(data_en), 64'd0);
    chk("t6_tag_en",    64'(tag_en), 64'd0);
    chk("t6_rec_count", 64'(rec_count), 64'd0);
    chk("t6_busy",      64'(busy), 64'd0);
    chk("t6_in_ready",  64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_idle_ready", 64'(in_ready), 64'd0);
    chk("t6_idle_done",  64'(done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_warmup_loader.md
# dcache_warmup_loader

Synthesizable front end for DCache functional warmup: accepts a stream of checkpoint records (tag entries and data rows) and writes them into the DCache tag array and data array through their normal RW0 SRAM ports, replacing simulation-only force/release injection. Optionally reads back each write and counts mismatches. Sits between the checkpoint record source (DMA/TSI-fed FIFO) and the `tag_array_ext` / `data_arrays_0_ext` RW0 ports, muxed in ahead of the DCache while the core is held in reset.

## Interface
- `SETS`, 64, cache sets; set index width `SB = $clog2(SETS)`
- `WAYS`, 4, associativity; way index width `WB`
- `ROWS`, 8, data rows per set (block 64 B / row 8 B); row index width `RB`
- `ROW_BYTES`, 8, bytes per row per way
- `TAG_BITS`, 22, raw tag (20) plus 2 coherency bits

- `clk`  in  1  clock (also drives the SRAM RW0_clk)
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  pulse; begin a load session
- `verify_en`  in  1  sampled at start; read back every write
- `in_valid` / `in_ready`  in / out  1  record handshake
- `in_kind`  in  1  0 = tag record, 1 = data record
- `in_way`  in  WB  target way
- `in_set`  in  SB  target set
- `in_row`  in  RB  data row (ignored for tag)
- `in_data`  in  64  payload; tag uses bits [TAG_BITS-1:0]
- `in_last`  in  1  final record of the session
- `tag_addr` / `tag_en` / `tag_wmode`  out  SB / 1 / 1  tag RW0 controls
- `tag_wdata`  out  WAYS*TAG_BITS (88)  tag write data
- `tag_wmask`  out  WAYS  per-way write mask
- `tag_rdata`  in  88  tag read data
- `data_addr` / `data_en` / `data_wmode`  out  SB+RB (9) / 1 / 1  data RW0 controls
- `data_wdata`  out  WAYS*ROW_BYTES*8 (256)  data write data
- `data_wmask`  out  WAYS*ROW_BYTES (32)  per-byte write mask
- `data_rdata`  in  256  data read data
- `busy` / `done`  out  1 / 1  session status
- `rec_count`  out  16  records accepted this session
- `err_count`  out  16  verify mismatches, saturating
- `err_valid` / `err_kind` / `err_way` / `err_addr`  out  1/1/WB/9  first mismatch capture

## Operation
- States: IDLE, LOAD, WRITE, READ, CHECK, DONE.
- IDLE/DONE: `start` -> LOAD; clears counts, `err_valid`, `done`; latches `verify_en`.
- LOAD: `in_ready=1`; on `in_valid` capture full record into registers -> WRITE.
- WRITE: one SRAM write from captured record. Tag: `tag_addr=set`, wdata = tag replicated across all lanes, `tag_wmask` one-hot at way. Data: `data_addr={set,row}`, wdata = payload replicated per way, `data_wmask` = 8 ones at bits [way*8 +: 8]. Then -> READ if verify latched, else last ? DONE : LOAD.
- READ: same address, `en=1`, `wmode=0`, mask 0 -> CHECK.
- CHECK: compare selected lane of rdata with captured payload; mismatch increments `err_count` (holds at 0xFFFF), captures first error. Then last ? DONE : LOAD.
- DONE: `done=1`, counts held until next `start`.
- `start` outside IDLE/DONE ignored. `rec_count` wraps at 2^16.

## Timing
- SRAM port outputs combinational from state + captured registers; en/wmode/wmask are 0 outside WRITE/READ.
- SRAM read latency 1: rdata valid in CHECK, cycle after READ.
- Throughput: 2 cycles/record without verify, 4 with.
- Reset (any state, async): state IDLE, all outputs 0, `in_ready=0`, SRAM enables deasserted same instant; partial sessions are discarded, no resume.
- `in_ready` is a function of state only, never of `in_valid`.

## Structure
- `dcache_warmup_pkg`: geometry constants, `kind_e`, `state_e`, functions for lane replicate/select and mask generation.
- Single module; no sub-module needed.

## Test plan
- Reset mid-WRITE -> `tag_en`/`data_en` drop immediately, state IDLE, `rec_count=0`.
- Tag record way 2, set 5, tag 0x2ABCDE, verify off -> one cycle with `tag_addr=5`, `tag_wmask=4'b0100`, lane 2 = 0x2ABCDE; `done` after last.
- Data record way 3, set 63, row 7, data 0x0123456789ABCDEF -> `data_addr=511`, `data_wmask=0xFF000000`; verify on, SRAM model returns same -> `err_count=0`.
- Verify on, SRAM model corrupts data way 1 set 0 row 1 -> `err_count=1`, `err_valid=1`, `err_kind=1`, `err_way=1`, `err_addr=1`.
- 256-record back-to-back stream, `in_valid` held high -> accepted every 2 cycles, `rec_count=256`, `done=1`.
- `start` pulsed in WRITE -> ignored; `start` in DONE -> counts cleared, new session.
